// File: rtl/imu_pkg.sv
// imu_pkg: MPU-6050 register map, device address and init sequencer state encoding
package imu_pkg;
    localparam logic [7:0] DEV_ADDR     = 8'h68;
    localparam logic [7:0] PWR_MGMT_1   = 8'h6B;
    localparam logic [7:0] SMPLRT_DIV   = 8'h19;
    localparam logic [7:0] CONFIG       = 8'h1A;
    localparam logic [7:0] GYRO_CONFIG  = 8'h1B;
    localparam logic [7:0] ACCEL_CONFIG = 8'h1C;
    typedef enum logic [2:0] {
        IDLE, SETTLE, LOAD, ISSUE, WAIT_ACCEPT, WAIT_DONE, GAP, DONE
    } state_t;
endpackage

// File: rtl/imu_init_rom.sv
// imu_init_rom: combinational lookup of the {reg, value} power-up write table
module imu_init_rom
    import imu_pkg::*;
#(
    parameter int NUM_CMDS = 5,
    localparam int IW = $clog2(NUM_CMDS) + 1
) (
    input  logic [IW-1:0] index,
    output logic [7:0]    reg_addr,
    output logic [7:0]    value
);
    logic valid;
    assign valid    = index < IW'(NUM_CMDS);
    assign reg_addr = !valid            ? 8'h00 :
                      index == IW'(0)   ? PWR_MGMT_1 :
                      index == IW'(1)   ? SMPLRT_DIV :
                      index == IW'(2)   ? CONFIG :
                      index == IW'(3)   ? GYRO_CONFIG :
                      index == IW'(4)   ? ACCEL_CONFIG : 8'h00;
    assign value    = valid && index == IW'(1) ? 8'h07 : 8'h00;
endmodule

// File: rtl/imu_init_sequencer.sv
// imu_init_sequencer: walks the MPU-6050 init table, one byte per transmitter send_en/is_busy handshake.
// Define IMU_INIT_SETTLE_EN to insert a SETTLE_CYCLES power-up wait after start.
module imu_init_sequencer
    import imu_pkg::*;
#(
    parameter int                   BUS_WIDTH      = 8,
    parameter logic [BUS_WIDTH-1:0] DEV_ADDR       = BUS_WIDTH'(imu_pkg::DEV_ADDR),
    parameter int                   NUM_CMDS       = 5,
    parameter int                   GAP_CYCLES     = 50,
    parameter int                   ACCEPT_TIMEOUT = 16,
    parameter int                   SETTLE_CYCLES  = 5_000_000,
    localparam int                  IW             = $clog2(NUM_CMDS) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 tx_busy,
    output logic [BUS_WIDTH-1:0] data_out,
    output logic                 is_addr,
    output logic                 send_en,
    output logic [IW-1:0]        cmd_index,
    output logic                 done,
    output logic                 seq_busy
);
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    localparam int AW = ACCEPT_TIMEOUT > 1 ? $clog2(ACCEPT_TIMEOUT) : 1;

    state_t        state;
    logic [1:0]    phase;
    logic [GW-1:0] gap_cnt;
    logic [AW-1:0] acc_cnt;
    logic [7:0]    rom_reg;
    logic [7:0]    rom_val;
`ifdef IMU_INIT_SETTLE_EN
    localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
    logic [SW-1:0] settle_cnt;
`endif

    imu_init_rom #(.NUM_CMDS(NUM_CMDS)) u_rom (
        .index    (cmd_index),
        .reg_addr (rom_reg),
        .value    (rom_val)
    );

    // Pulse in the ISSUE cycle itself so the request lands the cycle after LOAD.
    assign send_en = state == ISSUE && !tx_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            phase     <= 2'd0;
            gap_cnt   <= '0;
            acc_cnt   <= '0;
            data_out  <= '0;
            is_addr   <= 1'b0;
            cmd_index <= '0;
            done      <= 1'b0;
            seq_busy  <= 1'b0;
`ifdef IMU_INIT_SETTLE_EN
            settle_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    seq_busy <= 1'b1;
`ifdef IMU_INIT_SETTLE_EN
                    settle_cnt <= '0;
                    state      <= SETTLE;
`else
                    state <= LOAD;
`endif
                end
`ifdef IMU_INIT_SETTLE_EN
                SETTLE: if (settle_cnt == SW'(SETTLE_CYCLES - 1)) state <= LOAD;
                        else settle_cnt <= settle_cnt + 1'b1;
`endif
                LOAD: begin
                    data_out <= phase == 2'd0 ? DEV_ADDR : BUS_WIDTH'(phase == 2'd1 ? rom_reg : rom_val);
                    is_addr  <= phase == 2'd0;
                    state    <= ISSUE;
                end
                ISSUE: if (!tx_busy) begin
                    acc_cnt <= '0;
                    state   <= WAIT_ACCEPT;
                end
                WAIT_ACCEPT: if (tx_busy) state <= WAIT_DONE;
                             else if (acc_cnt == AW'(ACCEPT_TIMEOUT - 1)) state <= ISSUE;
                             else acc_cnt <= acc_cnt + 1'b1;
                WAIT_DONE: if (!tx_busy) begin
                    gap_cnt <= '0;
                    if (phase == 2'd2) begin
                        phase <= 2'd0;
                        if (cmd_index != IW'(NUM_CMDS)) cmd_index <= cmd_index + 1'b1;
                        state <= GAP;
                    end else begin
                        phase <= phase + 1'b1;
                        state <= LOAD;
                    end
                end
                GAP: if (gap_cnt != GW'(GAP_CYCLES - 1)) gap_cnt <= gap_cnt + 1'b1;
                     else if (cmd_index == IW'(NUM_CMDS)) begin
                         state    <= DONE;
                         done     <= 1'b1;
                         seq_busy <= 1'b0;
                     end else state <= LOAD;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_imu_init_sequencer.sv
// tb_imu_init_sequencer: scoreboard bench with a transmitter model busy 20 cycles per byte
`timescale 1ns/1ps
module tb_imu_init_sequencer;
    localparam int BUSY = 20;
    localparam int TOUT = 16;
`ifdef IMU_INIT_SETTLE_EN
    localparam int LAT = 102;
`else
    localparam int LAT = 2;
`endif
    localparam logic [7:0] EXP_BYTES [15] = '{
        8'h68, 8'h6B, 8'h00, 8'h68, 8'h19, 8'h07, 8'h68, 8'h1A,
        8'h00, 8'h68, 8'h1B, 8'h00, 8'h68, 8'h1C, 8'h00
    };

    logic       clk = 0, rst = 1, start = 0, model_busy = 0, hold_busy = 0;
    logic       tx_busy, is_addr, send_en, done, seq_busy, prev_send = 0;
    logic [7:0] data_out;
    logic [3:0] cmd_index;
    logic [8:0] q[$];
    int cyc = 0, seen = 0, ignore_at = -1, ign_cyc = 0, sc = 0, base = 0;
    int n_checks = 0, n_err = 0, lat = 0, n = 0;
    bit retry_pending = 0;

    assign tx_busy = model_busy | hold_busy;

    imu_init_sequencer #(.SETTLE_CYCLES(100)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .tx_busy   (tx_busy),
        .data_out  (data_out),
        .is_addr   (is_addr),
        .send_en   (send_en),
        .cmd_index (cmd_index),
        .done      (done),
        .seq_busy  (seq_busy)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push_all();
        for (int i = 0; i < 15; i++) q.push_back({i % 3 == 0, EXP_BYTES[i]});
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1;
        @(negedge clk) sc = cyc;
        @(posedge clk); #1 start = 0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_data"}, data_out, 0);
        check({tag, "_is_addr"}, is_addr, 0);
        check({tag, "_send_en"}, send_en, 0);
        check({tag, "_index"}, cmd_index, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_seq_busy"}, seq_busy, 0);
    endtask

    task automatic wait_done(input string tag);
        int k;
        logic pb;
        k = 0;
        pb = seq_busy;
        forever begin
            @(negedge clk);
            if (done === 1'b1 || k == 4000) break;
            pb = seq_busy;
            k++;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_fall"}, {pb, seq_busy}, 2'b10);
        check({tag, "_index"}, cmd_index, 5);
        check({tag, "_queue_left"}, q.size(), 0);
    endtask

    // No two consecutive send_en cycles, ever.
    always @(negedge clk) begin
        if (send_en === 1'b1) check("send_en_single", prev_send, 0);
        prev_send = send_en;
    end

    // Transmitter model: accepts a request the cycle after send_en and stays busy BUSY cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (send_en === 1'b1) begin
                if (seen == ignore_at) begin
                    check("ignored_byte", {is_addr, data_out}, q.size() > 0 ? q[0] : 9'h1ff);
                    retry_pending = 1;
                    ign_cyc = cyc;
                    seen++;
                end else begin
                    seen++;
                    if (retry_pending) begin
                        check("retry_gap", cyc - ign_cyc, TOUT + 1);
                        retry_pending = 0;
                    end
                    if (q.size() == 0) check("extra_tx", {is_addr, data_out}, 9'h1ff);
                    else check("tx_byte", {is_addr, data_out}, q.pop_front());
                    @(posedge clk); #1 model_busy = 1;
                    repeat (BUSY) @(posedge clk);
                    #1 model_busy = 0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check_reset("reset");

        // Full sequence, start ignored mid-run and after done.
        push_all();
        base = seen;
        pulse_start();
        n = 0;
        do begin @(negedge clk); n++; end while (send_en !== 1'b1 && n < 500);
        lat = cyc - sc;
        check("first_latency", lat, LAT);
        repeat (100) @(negedge clk);
        check("a_seq_busy", seq_busy, 1);
        pulse_start();
        wait_done("a");
        check("a_tx_count", seen - base, 15);
        base = seen;
        pulse_start();
        repeat (200) @(negedge clk);
        check("a_post_done_tx", seen - base, 0);
        check("a_post_done", done, 1);

        // Transmitter busy when ISSUE is reached.
        do_reset();
        hold_busy = 1;
        push_all();
        base = seen;
        pulse_start();
        repeat (10) @(negedge clk);
        check("b_held_tx", seen - base, 0);
        check("b_held_send", send_en, 0);
        @(posedge clk); #1 hold_busy = 0;
        @(negedge clk);
        check("b_release_send", send_en, 1);
        wait_done("b");

        // First request ignored: re-pulse after the accept timeout.
        do_reset();
        push_all();
        base = seen;
        ignore_at = seen;
        pulse_start();
        wait_done("c");
        check("c_tx_count", seen - base, 16);
        ignore_at = -1;

        // Reset during phase 1 of entry 2, then restart from entry 0.
        do_reset();
        push_all();
        base = seen;
        pulse_start();
        n = 0;
        while (seen - base < 8 && n < 2000) begin @(negedge clk); n++; end
        check("d_phase1_byte", {is_addr, data_out}, {1'b0, 8'h1A});
        check("d_phase1_index", cmd_index, 2);
        @(posedge clk); #1 rst = 1;
        q.delete();
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        check_reset("d_abort");
        push_all();
        pulse_start();
        wait_done("d");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
